// File: rtl/sd_resp_pkg.sv
// sd_block_responder shared types.
// State encoding and block geometry.
package sd_resp_pkg;

  localparam int BLK_BYTES = 512;
  localparam int IDX_W     = 9;

  typedef enum logic [2:0] {
    IDLE,
    DLY,
    RD_FETCH,
    RD_PUSH,
    WR_ADDR,
    WR_WAIT,
    WR_STORE,
    DONE
  } state_t;

endpackage

// File: rtl/sd_block_responder.sv
// Block-device responder serving 512-byte sd_* block transfers from a byte store.
// Optional write protect (wp/img_readonly) enabled by SD_RESP_WP_EN.
module sd_block_responder
  import sd_resp_pkg::*;
#(
  parameter int LBA_W   = 6,
  parameter int ACK_DLY = 4,
  parameter int BUF_LAT = 2
) (
  input  logic             clk_sys,
  input  logic             RESET_n,
  input  logic [31:0]      sd_lba,
  input  logic             sd_rd,
  input  logic             sd_wr,
  output logic             sd_ack,
  output logic [8:0]       sd_buff_addr,
  output logic [7:0]       sd_buff_dout,
  input  logic [7:0]       sd_buff_din,
  output logic             sd_buff_wr,
  output logic [LBA_W+8:0] mem_addr,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic [7:0]       mem_wdata,
  input  logic [7:0]       mem_rdata,
  input  logic             mem_ready
`ifdef SD_RESP_WP_EN
  ,
  input  logic             wp,
  output logic             img_readonly
`endif
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BLK_BYTES - 1);

  state_t             state;
  state_t             state_n;
  logic [LBA_W-1:0]   lba_q;
  logic               rd_q;
  logic               oor_q;
  logic               wp_q;
  logic               wp_in;
  logic [IDX_W-1:0]   idx;
  logic [3:0]         cnt;
  logic [7:0]         data_q;
  logic               last;
  logic               req;

`ifdef SD_RESP_WP_EN
  logic ro_q;

  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) ro_q <= 1'b0;
    else          ro_q <= wp;
  end

  assign img_readonly = ro_q;
  assign wp_in        = wp;
`else
  assign wp_in = 1'b0;
`endif

  assign last = (idx == IDX_LAST);
  assign req  = sd_rd | sd_wr;

  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:     if (req) state_n = DLY;
      DLY:
        if (cnt == 4'(ACK_DLY - 1))
          state_n = rd_q ? RD_FETCH : WR_ADDR;
      RD_FETCH: if (oor_q || mem_ready) state_n = RD_PUSH;
      RD_PUSH:  state_n = last ? DONE : RD_FETCH;
      WR_ADDR:  state_n = WR_WAIT;
      WR_WAIT:
        if (cnt >= 4'(BUF_LAT - 1))
          state_n = WR_STORE;
      WR_STORE:
        if (oor_q || wp_q || mem_ready)
          state_n = last ? DONE : WR_ADDR;
      DONE:     state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) begin
      lba_q  <= '0;
      rd_q   <= 1'b0;
      oor_q  <= 1'b0;
      wp_q   <= 1'b0;
      idx    <= '0;
      cnt    <= '0;
      data_q <= '0;
    end else begin
      unique case (state)
        IDLE:
          if (req) begin
            lba_q <= sd_lba[LBA_W-1:0];
            rd_q  <= sd_rd;
            oor_q <= |sd_lba[31:LBA_W];
            wp_q  <= wp_in;
            idx   <= '0;
            cnt   <= '0;
          end
        DLY: cnt <= cnt + 4'd1;
        RD_FETCH:
          if (oor_q)          data_q <= '0;
          else if (mem_ready) data_q <= mem_rdata;
        RD_PUSH:
          if (!last) idx <= idx + 1'b1;
        // WR_ADDR itself is the first cycle of buffer latency
        WR_ADDR: cnt <= 4'd1;
        WR_WAIT: begin
          cnt <= cnt + 4'd1;
          if (state_n == WR_STORE) data_q <= sd_buff_din;
        end
        WR_STORE:
          if (state_n == WR_ADDR) idx <= idx + 1'b1;
        default: ;
      endcase
    end
  end

  assign sd_ack       = (state == RD_FETCH) || (state == RD_PUSH) ||
                        (state == WR_ADDR)  || (state == WR_WAIT) ||
                        (state == WR_STORE);
  assign sd_buff_addr = idx;
  assign sd_buff_dout = data_q;
  assign sd_buff_wr   = (state == RD_PUSH);
  assign mem_addr     = {lba_q, idx};
  assign mem_rd       = (state == RD_FETCH) && !oor_q;
  assign mem_wr       = (state == WR_STORE) && !oor_q && !wp_q;
  assign mem_wdata    = data_q;

endmodule

// File: tb/tb_sd_block_responder.sv
// Directed bench for sd_block_responder with a random-latency byte store.
// Covers SD_RESP_WP_EN write protect when that macro is defined.
module tb_sd_block_responder;

  localparam int LBA_W   = 6;
  localparam int ACK_DLY = 4;
  localparam int BUF_LAT = 2;
  localparam int MEM_N   = 1 << (LBA_W + 9);

  logic             clk_sys = 1'b0;
  logic             RESET_n;
  logic [31:0]      sd_lba;
  logic             sd_rd;
  logic             sd_wr;
  logic             sd_ack;
  logic [8:0]       sd_buff_addr;
  logic [7:0]       sd_buff_dout;
  logic [7:0]       sd_buff_din;
  logic             sd_buff_wr;
  logic [LBA_W+8:0] mem_addr;
  logic             mem_rd;
  logic             mem_wr;
  logic [7:0]       mem_wdata;
  logic [7:0]       mem_rdata = 8'h00;
  logic             mem_ready = 1'b0;
`ifdef SD_RESP_WP_EN
  logic             wp;
  logic             img_readonly;
`endif

  always #5 clk_sys = ~clk_sys;

  sd_block_responder #(
    .LBA_W  (LBA_W),
    .ACK_DLY(ACK_DLY),
    .BUF_LAT(BUF_LAT)
  ) dut (
    .clk_sys     (clk_sys),
    .RESET_n     (RESET_n),
    .sd_lba      (sd_lba),
    .sd_rd       (sd_rd),
    .sd_wr       (sd_wr),
    .sd_ack      (sd_ack),
    .sd_buff_addr(sd_buff_addr),
    .sd_buff_dout(sd_buff_dout),
    .sd_buff_din (sd_buff_din),
    .sd_buff_wr  (sd_buff_wr),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_wr      (mem_wr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready)
`ifdef SD_RESP_WP_EN
    ,
    .wp          (wp),
    .img_readonly(img_readonly)
`endif
  );

  // Backing store: prefilled with addr[7:0], random 0..3 cycle ready delay
  logic [7:0] mem [0:MEM_N-1];
  bit         filled = 1'b0;
  int         mem_wait = 0;

  always @(posedge clk_sys) begin
    if (!filled) begin
      for (int i = 0; i < MEM_N; i++) mem[i] = i[7:0];
      filled = 1'b1;
    end
    mem_ready <= 1'b0;
    if ((mem_rd || mem_wr) && !mem_ready) begin
      if (mem_wait == 0) begin
        mem_ready <= 1'b1;
        if (mem_wr) mem[mem_addr] = mem_wdata;
        else        mem_rdata <= mem[mem_addr];
        mem_wait = $urandom_range(0, 3);
      end else begin
        mem_wait = mem_wait - 1;
      end
    end
  end

  // Core buffer holds ~idx; data is garbage until the address has been
  // stable across one clock edge, so an early sample is visible.
  logic [8:0] buf_q = 9'd0;
  always @(posedge clk_sys) buf_q <= sd_buff_addr;
  assign sd_buff_din = (buf_q == sd_buff_addr) ? ~buf_q[7:0] : 8'h5A;

  logic [7:0] exp_blk [0:511];
  int n_strobe = 0;
  int n_bad    = 0;
  int n_rd     = 0;
  int n_wr     = 0;
  int n_achg   = 0;
  int pos      = 0;
  int amin     = 0;
  int amax     = 0;
  logic [8:0] last_addr = 9'd0;

  always @(negedge clk_sys) begin
    if (!sd_ack) begin
      pos  = 0;
      amin = MEM_N;
      amax = -1;
    end
    if (sd_buff_wr) begin
      if (sd_buff_addr != pos[8:0] ||
          sd_buff_dout != exp_blk[pos[8:0]])
        n_bad++;
      pos++;
      n_strobe++;
    end
    if (mem_rd) begin
      n_rd++;
      if (int'(mem_addr) < amin) amin = int'(mem_addr);
      if (int'(mem_addr) > amax) amax = int'(mem_addr);
    end
    if (mem_wr) n_wr++;
    if (sd_buff_addr != last_addr) n_achg++;
    last_addr = sd_buff_addr;
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input string tag, input logic rd, input logic wr,
                      input logic [31:0] lba, input bit pre,
                      output int ds, output int dr, output int dw,
                      output int db);
    int n, s0, r0, w0, b0;
    if (!pre) begin
      @(posedge clk_sys); #1;
      sd_lba = lba;
      sd_rd  = rd;
      sd_wr  = wr;
    end
    s0 = n_strobe; r0 = n_rd; w0 = n_wr; b0 = n_bad;
    @(posedge clk_sys); #1;
    n = 0;
    while (!sd_ack && n < 40) begin
      @(posedge clk_sys); #1;
      n++;
    end
    sd_rd = 1'b0;
    sd_wr = 1'b0;
    chk({tag, "_ackdly"}, n, ACK_DLY);
    n = 0;
    while (sd_ack && n < 40000) begin
      @(posedge clk_sys); #1;
      n++;
    end
    chk({tag, "_ackfall"}, sd_ack, 1'b0);
    ds = n_strobe - s0;
    dr = n_rd - r0;
    dw = n_wr - w0;
    db = n_bad - b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ds, dr, dw, db, bad, n, a0;
    RESET_n = 1'b0;
    sd_lba  = 32'd0;
    sd_rd   = 1'b0;
    sd_wr   = 1'b0;
`ifdef SD_RESP_WP_EN
    wp      = 1'b0;
`endif
    repeat (3) @(posedge clk_sys);
    #1;
    chk("rst_ack", sd_ack, 1'b0);
    chk("rst_buf", {sd_buff_wr, sd_buff_addr, sd_buff_dout}, 0);
    chk("rst_memctl", {mem_rd, mem_wr}, 0);
    chk("rst_memdat", {mem_addr, mem_wdata}, 0);
    RESET_n = 1'b1;
    repeat (2) @(posedge clk_sys);

    for (int i = 0; i < 512; i++) exp_blk[i] = i[7:0];
    xfer("rd3", 1'b1, 1'b0, 32'd3, 1'b0, ds, dr, dw, db);
    chk("rd3_strobes", ds, 512);
    chk("rd3_stream", db, 0);
    chk("rd3_amin", amin, 32'h600);
    chk("rd3_amax", amax, 32'h7FF);
    chk("rd3_rdseen", dr >= 512, 1);
    chk("rd3_nowr", dw, 0);

    xfer("wr63", 1'b0, 1'b1, 32'd63, 1'b0, ds, dr, dw, db);
    chk("wr63_strobes", ds, 0);
    chk("wr63_nord", dr, 0);
    chk("wr63_wrseen", dw >= 512, 1);
    bad = 0;
    for (int i = 0; i < 512; i++)
      if (mem[32'h7E00 + i] !== ~i[7:0]) bad++;
    chk("wr63_data", bad, 0);
    chk("wr63_byte5", mem[32'h7E05], 8'hFA);

    for (int i = 0; i < 512; i++) exp_blk[i] = 8'h00;
    xfer("rd64", 1'b1, 1'b0, 32'd64, 1'b0, ds, dr, dw, db);
    chk("rd64_strobes", ds, 512);
    chk("rd64_zero", db, 0);
    chk("rd64_nord", dr, 0);

    xfer("wr64", 1'b0, 1'b1, 32'd64, 1'b0, ds, dr, dw, db);
    chk("wr64_nowr", dw, 0);
    bad = 0;
    for (int i = 0; i < 512; i++)
      if (mem[i] !== i[7:0]) bad++;
    chk("wr64_store", bad, 0);

    for (int i = 0; i < 512; i++) exp_blk[i] = i[7:0];
    xfer("both1", 1'b1, 1'b1, 32'd1, 1'b0, ds, dr, dw, db);
    chk("both1_strobes", ds, 512);
    chk("both1_stream", db, 0);
    chk("both1_nowr", dw, 0);

    @(posedge clk_sys); #1;
    sd_lba = 32'd5;
    sd_wr  = 1'b1;
    n = 0;
    while (!sd_ack && n < 40) begin
      @(posedge clk_sys); #1;
      n++;
    end
    sd_wr = 1'b0;
    n = 0;
    while (!(sd_buff_addr == 9'd200 && mem_wr) && n < 5000) begin
      @(negedge clk_sys);
      n++;
    end
    chk("mid_reach200", {mem_wr, sd_buff_addr}, {1'b1, 9'd200});
    #1;
    RESET_n = 1'b0;
    #1;
    chk("mid_ack", sd_ack, 1'b0);
    chk("mid_memwr", mem_wr, 1'b0);
    chk("mid_addr", sd_buff_addr, 0);
    bad = 0;
    for (int i = 0; i < 200; i++)
      if (mem[32'hA00 + i] !== ~i[7:0]) bad++;
    chk("mid_kept", bad, 0);
    bad = 0;
    for (int i = 201; i < 512; i++)
      if (mem[32'hA00 + i] !== i[7:0]) bad++;
    chk("mid_untouched", bad, 0);

    for (int i = 0; i < 512; i++) exp_blk[i] = mem[32'hA00 + i];
    sd_lba = 32'd5;
    sd_rd  = 1'b1;
    @(posedge clk_sys); #1;
    RESET_n = 1'b1;
    xfer("pre5", 1'b1, 1'b0, 32'd5, 1'b1, ds, dr, dw, db);
    chk("pre5_strobes", ds, 512);
    chk("pre5_stream", db, 0);

`ifdef SD_RESP_WP_EN
    wp = 1'b1;
    @(posedge clk_sys); #1;
    a0 = n_achg;
    xfer("wp2", 1'b0, 1'b1, 32'd2, 1'b0, ds, dr, dw, db);
    chk("wp2_nowr", dw, 0);
    chk("wp2_addrs", n_achg - a0, 512);
    chk("wp2_ro", img_readonly, 1'b1);
    bad = 0;
    for (int i = 0; i < 512; i++)
      if (mem[32'h400 + i] !== i[7:0]) bad++;
    chk("wp2_store", bad, 0);
`else
    a0 = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
